// File: rtl/dual_port_circ_q.sv
// dual_port_circ_q: two-lane in-order circular queue. Each cycle it can enqueue
// up to two entries and dequeue up to two entries.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   flush               synchronous clear of pointers, count and error flag
//   enq_valid[1:0]      per-lane enqueue request; lane 1 acts only together with lane 0
//   enq_data0/1         enqueue payloads for lane 0 / lane 1
//   enq_ready           combinational; at least two slots are free
//   deq_en[1:0]         per-lane dequeue request; lane 1 acts only together with lane 0
//   deq_data0/1         combinational head / head+1 entries
//   deq_valid[1:0]      head / head+1 hold valid data
//   count               occupancy, 0..DEPTH
//   full, empty         count==DEPTH / count==0
//   underflow_err       sticky; a dequeue asked for more entries than were held
//
// Optional feature: define DUAL_PORT_CIRC_Q_BYPASS_EN to pass lane-0 enqueue
// data straight to deq_data0 while the queue is empty.
module dual_port_circ_q #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [1:0]               enq_valid,
  input  logic [WIDTH-1:0]         enq_data0,
  input  logic [WIDTH-1:0]         enq_data1,
  output logic                     enq_ready,
  input  logic [1:0]               deq_en,
  output logic [WIDTH-1:0]         deq_data0,
  output logic [WIDTH-1:0]         deq_data1,
  output logic [1:0]               deq_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     underflow_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_head;
  logic [AW-1:0]    r_tail;
  logic [CW-1:0]    r_count;
  logic             r_underflow;

  logic [1:0]       w_n_enq_req;
  logic [1:0]       w_n_deq_req;
  logic [1:0]       w_n_enq;
  logic [1:0]       w_n_deq;
  logic [1:0]       w_tail_adv;
  logic             w_under;
  logic             w_wr0_en;
  logic [WIDTH-1:0] w_wr0_data;
  logic             w_wr1_en;
  logic             w_bypass;

  // Lane decode: 2'b10 is not a legal request and is treated as no request.
  always_comb begin
    case (enq_valid)
      2'b01:   w_n_enq_req = 2'd1;
      2'b11:   w_n_enq_req = 2'd2;
      default: w_n_enq_req = 2'd0;
    endcase
    case (deq_en)
      2'b01:   w_n_deq_req = 2'd1;
      2'b11:   w_n_deq_req = 2'd2;
      default: w_n_deq_req = 2'd0;
    endcase
  end

  // Ready looks only at the registered count, so a same-cycle pop never opens room.
  assign enq_ready = (CW'(DEPTH) - r_count) >= CW'(2);

  // Per-cycle transfer amounts, write enables and the error condition.
  always_comb begin
    w_n_enq    = enq_ready ? w_n_enq_req : 2'd0;
    w_under    = CW'(w_n_deq_req) > r_count;
    w_n_deq    = w_under ? r_count[1:0] : w_n_deq_req;
    w_wr0_en   = w_n_enq != 2'd0;
    w_wr0_data = enq_data0;
    w_wr1_en   = w_n_enq == 2'd2;
    w_tail_adv = w_n_enq;
    w_bypass   = 1'b0;
`ifdef DUAL_PORT_CIRC_Q_BYPASS_EN
    w_bypass = (r_count == '0) && enq_valid[0] && enq_ready;
    // Lane 0 is consumed on the fly; only lane-1 data (if any) lands in storage.
    if (w_bypass && deq_en[0]) begin
      w_wr0_en   = w_n_enq == 2'd2;
      w_wr0_data = enq_data1;
      w_wr1_en   = 1'b0;
      w_tail_adv = w_wr0_en ? 2'd1 : 2'd0;
      w_n_deq    = 2'd0;
      w_under    = deq_en[1];
    end
`endif
  end

  // Pointer, occupancy and sticky error state.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_underflow <= 1'b0;
    end else begin
      r_head      <= r_head + AW'(w_n_deq);
      r_tail      <= r_tail + AW'(w_tail_adv);
      r_count     <= r_count + CW'(w_tail_adv) - CW'(w_n_deq);
      r_underflow <= r_underflow | w_under;
    end
  end

  // Storage is never cleared; writes are suppressed on reset and flush cycles.
  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      if (w_wr0_en) r_mem[r_tail] <= w_wr0_data;
      if (w_wr1_en) r_mem[r_tail + AW'(1)] <= enq_data1;
    end
  end

  // Read side.
  always_comb begin
    deq_valid[0] = (r_count >= CW'(1)) | w_bypass;
    deq_valid[1] = r_count >= CW'(2);
    deq_data0    = w_bypass ? enq_data0 : r_mem[r_head];
    deq_data1    = r_mem[r_head + AW'(1)];
  end

  assign count         = r_count;
  assign full          = r_count == CW'(DEPTH);
  assign empty         = r_count == '0;
  assign underflow_err = r_underflow;

endmodule

// File: doc/dual_port_circ_q.md
DUAL_PORT_CIRC_Q -- requirements
Module: dual_port_circ_q

Interface
REQ-001 The block SHALL take parameter WIDTH, default 32, meaning the entry width in bits.
REQ-002 The block SHALL take parameter DEPTH, default 16, meaning the entry count; DEPTH SHALL be a power of two and at least 4.
REQ-003 The block SHALL have port clk, input, 1 bit: the clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 The block SHALL have port flush, input, 1 bit: synchronous queue clear.
REQ-006 The block SHALL have port enq_valid, input, 2 bits: per-lane enqueue request.
REQ-007 The block SHALL have ports enq_data0 and enq_data1, input, WIDTH bits each: the enqueue payloads for lane 0 and lane 1.
REQ-008 The block SHALL have port enq_ready, output, 1 bit: free slots are at least 2.
REQ-009 The block SHALL have port deq_en, input, 2 bits: per-lane dequeue request.
REQ-010 The block SHALL have ports deq_data0 and deq_data1, output, WIDTH bits each: the head entry and the head+1 entry.
REQ-011 The block SHALL have port deq_valid, output, 2 bits: per-lane head data valid.
REQ-012 The block SHALL have port count, output, $clog2(DEPTH)+1 bits: the occupancy.
REQ-013 The block SHALL have ports full and empty, output, 1 bit each: count==DEPTH and count==0 respectively.
REQ-014 The block SHALL have port underflow_err, output, 1 bit: sticky flag set on an over-request dequeue.

Function
REQ-015 The block SHALL treat lanes in order:
- lane 1 acts only with lane 0;
- enq_valid==2'b10 and deq_en==2'b10 are ignored;
- an ignored deq_en==2'b10 does not set underflow_err.
REQ-016 enq_ready SHALL be combinational: (DEPTH-count)>=2, using the registered count; a same-cycle dequeue does not raise it.
REQ-017 Enqueue SHALL occur only when enq_ready=1:
- 2'b01 writes enq_data0 at tail, and tail advances by 1;
- 2'b11 writes enq_data0 at tail and enq_data1 at tail+1, and tail advances by 2.
REQ-018 An enqueue request with enq_ready=0 SHALL be dropped with no state change; the producer must hold the request.
REQ-019 deq_data0=storage[head] and deq_data1=storage[head+1] SHALL be combinational; deq_valid[0]=(count>=1) and deq_valid[1]=(count>=2).
REQ-020 Dequeue SHALL pop n = min(requested lanes, count) entries, and head SHALL advance by n.
REQ-021 When the requested lanes exceed count, underflow_err SHALL be set on the next edge; it holds until rst or flush.
REQ-022 All pointer arithmetic SHALL be modulo DEPTH, with wrap via the low $clog2(DEPTH) bits.
REQ-023 On each edge count SHALL update to count + n_enq - n_deq; simultaneous enqueue and dequeue are legal in any combination.
REQ-024 Simultaneous enqueue and dequeue at full or near-full SHALL follow REQ-016 and REQ-018: no enqueue when free<2, even if a dequeue occurs the same cycle.
REQ-025 flush=1 SHALL act as a synchronous clear on the same edge:
- head, tail, count and underflow_err go to 0;
- same-cycle enq_valid and deq_en are ignored;
- storage contents become don't-care.
REQ-026 rst SHALL have priority over flush, and flush SHALL have priority over enqueue and dequeue.

Reset
REQ-027 While rst=1 at an edge, the block SHALL set head=0, tail=0, count=0 and underflow_err=0.
REQ-028 Storage SHALL NOT be cleared by reset; storage contents are don't-care.
REQ-029 After reset the outputs SHALL be:
- empty=1, full=0, enq_ready=1;
- deq_valid=2'b00;
- deq_data0 and deq_data1 don't-care.
REQ-030 Reset asserted mid-operation SHALL discard all entries and any in-flight request on that edge.

Configuration
REQ-031 Macro DUAL_PORT_CIRC_Q_BYPASS_EN SHALL enable lane-0 bypass when defined.
- Condition: count==0, enq_valid[0]=1 and enq_ready=1.
- Output: deq_valid[0]=1 and deq_data0=enq_data0 combinationally.
- If deq_en[0]=1 the same cycle, enq_data0 is consumed and not written: tail does not advance for it, and enq_data1 (if valid) is written at tail.
- Net count change is 0 or 1.
- underflow_err is not set for lane 0 in this case.
REQ-032 Without DUAL_PORT_CIRC_Q_BYPASS_EN:
- deq_valid[0]=0 whenever count==0;
- a same-cycle deq_en[0] with count==0 sets underflow_err;
- the enqueue proceeds normally.

Verification (WIDTH=32, DEPTH=8)
REQ-033 The bench SHALL cover fill and drain: reset, then enqueue pairs 0x1..0x8 over 4 cycles -> count=8, full=1, enq_ready=0; then dequeue 2'b11 four times -> pairs (1,2),(3,4),(5,6),(7,8), then empty=1.
REQ-034 The bench SHALL cover back-pressure: at count=7, enq_valid=2'b01 with deq_en=2'b01 -> the enqueue is dropped, count=6, and enq_ready=1 on the next cycle.
REQ-035 The bench SHALL cover wrap: 20 cycles of enq 2'b11 plus deq 2'b11 from count=4 -> order preserved across the wrap and count stays at 4.
REQ-036 The bench SHALL cover underflow: at count=1, deq_en=2'b11 -> one entry popped, count=0, underflow_err=1; then flush -> underflow_err=0.
REQ-037 The bench SHALL cover bypass: empty queue, enq_valid=2'b01 with data 0xAB and deq_en=2'b01 -> with the macro, deq_data0=0xAB and deq_valid[0]=1 in the same cycle, count stays 0; without the macro, underflow_err=1 and count=1.
REQ-038 The bench SHALL cover flush versus traffic: count=5 with flush=1, enq=2'b11 and deq=2'b11 -> count=0, empty=1, and no entry is written.
